// File: rtl/decoder_pulse_ctrl.sv
// Registered IN_W-to-OUT_W one-hot decoder with valid/ready handshake and hold/pulse output modes.
// Define DECODER_PULSE_ERR_EN to drop illegal codes and flag them on err; otherwise they clear.
module decoder_pulse_ctrl #(
    parameter int unsigned IN_W      = 2,
    parameter int unsigned OUT_W     = 4,
    parameter int unsigned PULSE_LEN = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  in,
    input  logic             en,
    input  logic             mode,
    input  logic             valid,
    output logic             ready,
    output logic [OUT_W-1:0] out,
    output logic             busy,
    output logic             err
);

    localparam int unsigned CNT_W = $clog2(PULSE_LEN + 1);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StHold  = 2'd1;
    localparam logic [1:0] StPulse = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [OUT_W-1:0] out_q, out_d;
    logic [OUT_W-1:0] dec;
    logic             accept;
    logic             legal;
    logic             err_d;

    assign ready  = (state_q != StPulse);
    assign busy   = (state_q != StIdle);
    assign out    = out_q;
    assign accept = valid && ready;
    assign legal  = (32'(in) < OUT_W);

    always_comb begin
        dec = '0;
        for (int unsigned i = 0; i < OUT_W; i++) begin
            if (in == IN_W'(i)) begin
                dec[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        err_d   = 1'b0;
        if (state_q == StPulse) begin
            // Counter is loaded with PULSE_LEN-1, so exit on zero gives PULSE_LEN high cycles.
            if (cnt_q != '0) begin
                cnt_d = cnt_q - CNT_W'(1);
            end else begin
                out_d   = '0;
                state_d = StIdle;
            end
        end else if (accept) begin
            if (!en) begin
                out_d   = '0;
                state_d = StIdle;
                cnt_d   = '0;
            end else if (legal) begin
                out_d = dec;
                if (mode) begin
                    state_d = StPulse;
                    cnt_d   = CNT_W'(PULSE_LEN - 1);
                end else begin
                    state_d = StHold;
                    cnt_d   = '0;
                end
            end else begin
`ifdef DECODER_PULSE_ERR_EN
                err_d = 1'b1;
`else
                out_d   = '0;
                state_d = StIdle;
                cnt_d   = '0;
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

`ifdef DECODER_PULSE_ERR_EN
    logic err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;

    logic unused_err;
    assign unused_err = err_d;
`endif

    a_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(out_q));
    a_idle_zero: assert property (@(posedge clk) disable iff (rst)
        (state_q == StIdle) |-> (out_q == '0));

endmodule
